// File: rtl/serial_adder_if.sv
// Handshake/result bundle for serial_adder; the cin member exists only when
// SERIAL_ADDER_CIN_EN is defined. WIDTH must match the adder's WIDTH.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_CIN_EN
    logic             cin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADDER_CIN_EN
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, one bit per clock, LSB first, WIDTH cycles per add.
// Define SERIAL_ADDER_CIN_EN to add a cin input used as the initial carry.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, psum_q, sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, cout_q;
    logic             load, step, last;
    logic             s_bit, c_next, cin_bit;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_bit = bus.cin;
`else
    assign cin_bit = 1'b0;
`endif

    assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here: a busy adder ignores requests.
                step = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (load) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= cin_bit;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            psum_q  <= {s_bit, psum_q[WIDTH-1:1]};
            carry_q <= c_next;
            cnt_q   <= cnt_q + CW'(1);
            // The visible result only changes once the final bit is in.
            if (last) begin
                sum_q  <= {s_bit, psum_q[WIDTH-1:1]};
                cout_q <= c_next;
            end
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to add a and b; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured only when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured only when start is accepted.
REQ-007 busy  output  1  high while an addition is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid new result.
REQ-009 sum  output  WIDTH  registered result of the last completed addition.
REQ-010 cout  output  1  registered carry-out of the last completed addition.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE with start=1, the block SHALL capture a and b into shift registers, load the carry flop with the initial carry, clear a bit counter to 0, and enter SHIFT.
REQ-013 In SHIFT, each cycle SHALL process one bit, LSB first: s = a0^b0^c; next c = a0&b0 | c&(a0^b0); s is shifted into the MSB of a partial-sum register; the operand registers shift right.
REQ-014 After WIDTH SHIFT cycles (counter = WIDTH-1 at the edge), the block SHALL load sum from the completed partial sum and cout from the final carry, then enter DONE.
REQ-015 Latency: if start is accepted at edge T, done SHALL be high for exactly the cycle between edges T+WIDTH and T+WIDTH+1.
REQ-016 busy SHALL be high in SHIFT and low in IDLE and DONE.
REQ-017 sum and cout SHALL hold their value between completions; partial results SHALL never appear on sum.
REQ-018 DONE SHALL last one cycle and then move to IDLE, unless start=1, in which case it moves to SHIFT (back-to-back operation, no bubble).
REQ-019 start SHALL be ignored while busy=1; a, b and the running carry SHALL be unaffected by input changes in SHIFT.
REQ-020 The counter SHALL be wide enough for WIDTH-1 and SHALL reset to 0 on each accepted start.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.

Reset
REQ-022 While reset=1, asynchronously: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, and the shift registers=0.
REQ-023 A reset during SHIFT SHALL abort the operation: no done pulse, and sum/cout read 0.
REQ-024 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro SERIAL_ADDER_CIN_EN.
- When defined: add input port cin (1 bit), sampled with start and used as the initial carry.
- When undefined: no cin port, and the initial carry is 0.

Verification
REQ-026 Directed scenarios, WIDTH=8:
- reset, then start with a=8'h00, b=8'h00 -> done at T+8; sum=8'h00, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; sum stays 8'h00 during SHIFT of the next operation.
- a=8'hA5, b=8'h5A; start held high and a/b changed to 8'h11 mid-operation -> sum=8'hFF, cout=0; extra start ignored.
- a=8'h80, b=8'h80, with start asserted in the DONE cycle for a=8'h03, b=8'h04 -> first result sum=8'h00, cout=1; second result sum=8'h07, cout=0 exactly 8 cycles later.
- reset asserted at cycle 4 of a=8'h7F+8'h01 -> immediate IDLE; busy=0, sum=8'h00, cout=0, no done pulse.
- with SERIAL_ADDER_CIN_EN: a=8'hFE, b=8'h01, cin=1 -> sum=8'h00, cout=1.
